// File: rtl/tod_pkg.sv
// Shared BCD types, limits and helpers for the time-of-day clock.
// Consumers: bcd_mod_counter and time_of_day_bcd (alarm gated by TOD_ALARM_EN).
package tod_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_byte_t;

  localparam bcd_byte_t MIN_SEC_MAX = 8'h59;
  localparam bcd_byte_t HOUR_MAX    = 8'h23;
  localparam bcd_byte_t HOUR_NOON   = 8'h12;

  function automatic logic bcd_ok(input bcd_byte_t v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [6:0] bcd2bin(input bcd_byte_t v);
    return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
  endfunction

  function automatic bcd_byte_t bin2bcd(input logic [6:0] b);
    bcd_digit_t hi;
    bcd_digit_t lo;
    hi = 4'(b / 7'd10);
    lo = 4'(b % 7'd10);
    return {hi, lo};
  endfunction

  // 24-hour BCD hour to 12-hour display digits (00 and 12 both show as 12).
  function automatic bcd_byte_t to12(input bcd_byte_t h24);
    if (h24 == 8'h00)           return HOUR_NOON;
    else if (h24 <= HOUR_NOON)  return h24;
    else                        return bin2bcd(bcd2bin(h24) - 7'd12);
  endfunction

  function automatic bcd_byte_t to24(input bcd_byte_t h12, input logic pm);
    if (h12 == HOUR_NOON) return pm ? HOUR_NOON : 8'h00;
    else if (pm)          return bin2bcd(bcd2bin(h12) + 7'd12);
    else                  return h12;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at LIMIT, with synchronous load and carry-out.
// val_d_o exposes the next-state value so the parent can register derived outputs.
module bcd_mod_counter
  import tod_pkg::*;
#(
  parameter bcd_byte_t LIMIT = 8'h59
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      inc_i,
  input  logic      load_i,
  input  bcd_byte_t load_val_i,
  output bcd_byte_t val_o,
  output bcd_byte_t val_d_o,
  output logic      carry_o
);

  bcd_byte_t val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (reset) begin
      val_d = 8'h00;
    end else if (load_i) begin
      val_d = load_val_i;
    end else if (inc_i) begin
      if (val_q == LIMIT)          val_d = 8'h00;
      else if (val_q[3:0] == 4'd9) val_d = {val_q[7:4] + 4'd1, 4'd0};
      else                         val_d = {val_q[7:4], val_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    val_q <= val_d;
  end

  assign val_o   = val_q;
  assign val_d_o = val_d;
  assign carry_o = inc_i && (val_q == LIMIT);

endmodule

// File: rtl/time_of_day_bcd.sv
// BCD time-of-day clock: 24-hour internal time, 12/24-hour registered display,
// validated loads; optional alarm compiled in with TOD_ALARM_EN.
module time_of_day_bcd
  import tod_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int TICK_W   = 10
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      ena,
  input  logic      mode24,
  input  logic      load,
  input  bcd_byte_t load_hh,
  input  bcd_byte_t load_mm,
  input  bcd_byte_t load_ss,
  input  logic      load_pm,
  output bcd_byte_t hh,
  output bcd_byte_t mm,
  output bcd_byte_t ss,
  output logic      pm,
  output logic      sec_pulse,
  output logic      load_err
`ifdef TOD_ALARM_EN
  ,
  input  bcd_byte_t alarm_hh,
  input  bcd_byte_t alarm_mm,
  input  logic      alarm_arm,
  output logic      alarm
`endif
);

  logic [TICK_W-1:0] presc_q, presc_d;
  logic      tick, adv, load_ok, load_valid;
  bcd_byte_t load_hour24;
  bcd_byte_t sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic      sec_co, min_co, hour_co;
  bcd_byte_t hh_q;
  logic      pm_q, sec_pulse_q, load_err_q;
  logic      unused_ok;

  assign tick = ena && (presc_q == TICK_W'(TICK_DIV - 1));
  // Any load request claims the cycle, so a coincident tick never advances time.
  assign adv  = tick && !load;

  always_comb begin
    load_ok = bcd_ok(load_mm) && (load_mm <= MIN_SEC_MAX) &&
              bcd_ok(load_ss) && (load_ss <= MIN_SEC_MAX) && bcd_ok(load_hh);
    if (mode24) load_ok = load_ok && (load_hh <= HOUR_MAX);
    else        load_ok = load_ok && (load_hh != 8'h00) && (load_hh <= HOUR_NOON);
    load_hour24 = mode24 ? load_hh : to24(load_hh, load_pm);
  end

  assign load_valid = load && load_ok;

  always_comb begin
    presc_d = presc_q;
    if (reset)           presc_d = '0;
    else if (load)       presc_d = load_ok ? '0 : presc_q;
    else if (tick)       presc_d = '0;
    else if (ena)        presc_d = presc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    presc_q <= presc_d;
  end

  bcd_mod_counter #(.LIMIT(MIN_SEC_MAX)) u_sec (
    .clk(clk), .reset(reset), .inc_i(adv), .load_i(load_valid), .load_val_i(load_ss),
    .val_o(sec_q), .val_d_o(sec_d), .carry_o(sec_co)
  );

  bcd_mod_counter #(.LIMIT(MIN_SEC_MAX)) u_min (
    .clk(clk), .reset(reset), .inc_i(sec_co), .load_i(load_valid), .load_val_i(load_mm),
    .val_o(min_q), .val_d_o(min_d), .carry_o(min_co)
  );

  bcd_mod_counter #(.LIMIT(HOUR_MAX)) u_hour (
    .clk(clk), .reset(reset), .inc_i(min_co), .load_i(load_valid), .load_val_i(load_hour24),
    .val_o(hour_q), .val_d_o(hour_d), .carry_o(hour_co)
  );

  // Hour display is built from the counter's next state so it lands with mm/ss.
  always_ff @(posedge clk) begin
    if (reset) begin
      hh_q        <= mode24 ? 8'h00 : HOUR_NOON;
      pm_q        <= 1'b0;
      sec_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      hh_q        <= mode24 ? hour_d : to12(hour_d);
      pm_q        <= (hour_d >= HOUR_NOON);
      sec_pulse_q <= adv;
      load_err_q  <= load && !load_ok;
    end
  end

  assign hh        = hh_q;
  assign mm        = min_q;
  assign ss        = sec_q;
  assign pm        = pm_q;
  assign sec_pulse = sec_pulse_q;
  assign load_err  = load_err_q;

`ifdef TOD_ALARM_EN
  logic alarm_q;

  always_ff @(posedge clk) begin
    if (reset)           alarm_q <= 1'b0;
    else if (!alarm_arm) alarm_q <= 1'b0;
    else if (adv && (hour_d == alarm_hh) && (min_d == alarm_mm) && (sec_d == 8'h00))
      alarm_q <= 1'b1;
  end

  assign alarm = alarm_q;
`endif

  assign unused_ok = ^{hour_q, min_d, sec_d, hour_co};

endmodule

// File: tb/tb_time_of_day_bcd.sv
// Bench for time_of_day_bcd: TICK_DIV=1 and TICK_DIV=4 instances share stimulus and
// are checked against a seconds-of-day reference model; alarm checks need TOD_ALARM_EN.
module tb_time_of_day_bcd;

  logic       clk = 1'b0;
  logic       reset = 1'b1, ena = 1'b0, mode24 = 1'b0, load = 1'b0, load_pm = 1'b0;
  logic [7:0] load_hh = 8'h00, load_mm = 8'h00, load_ss = 8'h00;
  logic [7:0] alarm_hh = 8'h00, alarm_mm = 8'h00;
  logic       alarm_arm = 1'b0;

  logic [7:0] hh_w [2];
  logic [7:0] mm_w [2];
  logic [7:0] ss_w [2];
  logic       pm_w [2];
  logic       sp_w [2];
  logic       le_w [2];
  logic       al_w [2];

  int tests = 0;
  int fails = 0;

  int div_m [2] = '{1, 4};
  int t_m   [2];
  int pre_m [2];
  bit sp_m  [2];
  bit le_m  [2];
  bit al_m  [2];

  always #5 clk = ~clk;

  time_of_day_bcd #(.TICK_DIV(1), .TICK_W(10)) u1 (
    .clk(clk), .reset(reset), .ena(ena), .mode24(mode24), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
    .hh(hh_w[0]), .mm(mm_w[0]), .ss(ss_w[0]), .pm(pm_w[0]),
    .sec_pulse(sp_w[0]), .load_err(le_w[0])
`ifdef TOD_ALARM_EN
    , .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm), .alarm(al_w[0])
`endif
  );

  time_of_day_bcd #(.TICK_DIV(4), .TICK_W(10)) u4 (
    .clk(clk), .reset(reset), .ena(ena), .mode24(mode24), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
    .hh(hh_w[1]), .mm(mm_w[1]), .ss(ss_w[1]), .pm(pm_w[1]),
    .sec_pulse(sp_w[1]), .load_err(le_w[1])
`ifdef TOD_ALARM_EN
    , .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm), .alarm(al_w[1])
`endif
  );

`ifndef TOD_ALARM_EN
  assign al_w[0] = 1'b0;
  assign al_w[1] = 1'b0;
`endif

  function automatic logic [7:0] bcd(input int x);
    logic [7:0] r;
    r[7:4] = 4'(x / 10);
    r[3:0] = 4'(x % 10);
    return r;
  endfunction

  function automatic int dec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit digits_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: time as seconds since midnight, prescaler as a plain count.
  task automatic model_edge();
    bit valid;
    int h;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        t_m[i] = 0; pre_m[i] = 0; sp_m[i] = 0; le_m[i] = 0; al_m[i] = 0;
      end else begin
        sp_m[i] = 0;
        le_m[i] = 0;
        if (load) begin
          valid = digits_ok(load_hh) && digits_ok(load_mm) && digits_ok(load_ss) &&
                  dec(load_mm) <= 59 && dec(load_ss) <= 59 &&
                  (mode24 ? dec(load_hh) <= 23 : (dec(load_hh) >= 1 && dec(load_hh) <= 12));
          if (valid) begin
            h = dec(load_hh);
            if (!mode24) h = (h % 12) + (load_pm ? 12 : 0);
            t_m[i]   = h * 3600 + dec(load_mm) * 60 + dec(load_ss);
            pre_m[i] = 0;
          end else begin
            le_m[i] = 1;
          end
        end else if (ena) begin
          pre_m[i]++;
          if (pre_m[i] == div_m[i]) begin
            pre_m[i] = 0;
            t_m[i]   = (t_m[i] + 1) % 86400;
            sp_m[i]  = 1;
            if (alarm_arm && t_m[i] / 3600 == dec(alarm_hh) &&
                (t_m[i] / 60) % 60 == dec(alarm_mm) && t_m[i] % 60 == 0)
              al_m[i] = 1;
          end
        end
        if (!alarm_arm) al_m[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    int h;
    string p;
    for (int i = 0; i < 2; i++) begin
      h = t_m[i] / 3600;
      p = $sformatf("div%0d.", div_m[i]);
      chk({p, "hh"}, hh_w[i], mode24 ? bcd(h) : bcd((h % 12 == 0) ? 12 : h % 12));
      chk({p, "mm"}, mm_w[i], bcd((t_m[i] / 60) % 60));
      chk({p, "ss"}, ss_w[i], bcd(t_m[i] % 60));
      chk({p, "pm"}, 8'(pm_w[i]), 8'(h >= 12));
      chk({p, "sec_pulse"}, 8'(sp_w[i]), 8'(sp_m[i]));
      chk({p, "load_err"}, 8'(le_w[i]), 8'(le_m[i]));
`ifdef TOD_ALARM_EN
      chk({p, "alarm"}, 8'(al_w[i]), 8'(al_m[i]));
`endif
    end
  endtask

  task automatic step(input logic r, input logic e, input logic l);
    @(negedge clk);
    reset = r;
    ena   = e;
    load  = l;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic p);
    load_hh = h; load_mm = m; load_ss = s; load_pm = p;
  endtask

  initial begin
    // Reset state in both display modes
    mode24 = 1'b0;
    step(1, 0, 0);
    step(1, 1, 1);
    chk("rst.hh12", hh_w[0], 8'h12);
    chk("rst.ss", ss_w[0], 8'h00);
    chk("rst.pm", 8'(pm_w[0]), 8'h00);
    mode24 = 1'b1;
    step(1, 0, 0);
    chk("rst.hh24", hh_w[0], 8'h00);
    mode24 = 1'b0;
    step(1, 0, 0);

    // One qualifying ena at TICK_DIV=1
    step(0, 1, 0);
    chk("tick1.hh", hh_w[0], 8'h12);
    chk("tick1.ss", ss_w[0], 8'h01);
    chk("tick1.sp", 8'(sp_w[0]), 8'h01);
    chk("tick1.div4_ss", ss_w[1], 8'h00);
    step(0, 0, 0);
    chk("tick1.sp_off", 8'(sp_w[0]), 8'h00);

    // 11:59:59 PM rolls to 12:00:00 AM (00 in 24-hour mode)
    set_load(8'h11, 8'h59, 8'h59, 1'b1);
    step(0, 0, 1);
    chk("pmload.pm", 8'(pm_w[0]), 8'h01);
    step(0, 1, 0);
    chk("midnight.hh", hh_w[0], 8'h12);
    chk("midnight.mm", mm_w[0], 8'h00);
    chk("midnight.pm", 8'(pm_w[0]), 8'h00);
    mode24 = 1'b1;
    step(0, 0, 0);
    chk("midnight.hh24", hh_w[0], 8'h00);

    // Prescaler at TICK_DIV=4, and a load clearing a partial count
    mode24 = 1'b0;
    step(1, 0, 0);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    chk("div4.3ena", ss_w[1], 8'h00);
    step(0, 1, 0);
    chk("div4.4ena", ss_w[1], 8'h01);
    chk("div4.sp", 8'(sp_w[1]), 8'h01);
    step(0, 1, 0); step(0, 1, 0);
    mode24 = 1'b1;
    set_load(8'h00, 8'h00, 8'h10, 1'b0);
    step(0, 0, 1);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    chk("div4.after_load3", ss_w[1], 8'h10);
    step(0, 1, 0);
    chk("div4.after_load4", ss_w[1], 8'h11);

    // Rejected loads, and load beating a coincident tick
    mode24 = 1'b0;
    set_load(8'h13, 8'h00, 8'h00, 1'b0);
    step(0, 0, 1);
    chk("badhh.err", 8'(le_w[0]), 8'h01);
    step(0, 0, 0);
    chk("badhh.err_off", 8'(le_w[0]), 8'h00);
    set_load(8'h05, 8'h5A, 8'h00, 1'b0);
    step(0, 0, 1);
    chk("badmm.err", 8'(le_w[0]), 8'h01);
    set_load(8'h10, 8'h20, 8'h30, 1'b0);
    step(0, 1, 1);
    chk("loadwin.ss", ss_w[0], 8'h30);
    chk("loadwin.sp", 8'(sp_w[0]), 8'h00);

    // Mode switch with time held at 13:05:00
    mode24 = 1'b1;
    set_load(8'h13, 8'h05, 8'h00, 1'b0);
    step(0, 0, 1);
    mode24 = 1'b0;
    step(0, 0, 0);
    chk("mode.hh", hh_w[0], 8'h01);
    chk("mode.pm", 8'(pm_w[0]), 8'h01);
    chk("mode.ss", ss_w[0], 8'h00);

    // Alarm at 07:30
    mode24 = 1'b1;
    alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_arm = 1'b1;
    set_load(8'h07, 8'h29, 8'h59, 1'b0);
    step(0, 0, 1);
`ifdef TOD_ALARM_EN
    chk("alarm.load_no_trig", 8'(al_w[0]), 8'h00);
`endif
    step(0, 1, 0);
    step(0, 0, 0);
`ifdef TOD_ALARM_EN
    chk("alarm.set", 8'(al_w[0]), 8'h01);
`endif
    alarm_arm = 1'b0;
    step(0, 0, 0);
`ifdef TOD_ALARM_EN
    chk("alarm.disarm", 8'(al_w[0]), 8'h00);
`endif
    alarm_arm = 1'b1;
    step(0, 0, 1);
    step(0, 1, 0);
    step(1, 0, 0);
`ifdef TOD_ALARM_EN
    chk("alarm.reset", 8'(al_w[0]), 8'h00);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic r, e, l;
      r = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 14) == 0);
      e = l ? 1'b0 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) mode24 = ~mode24;
      if ($urandom_range(0, 49) == 0) alarm_arm = ~alarm_arm;
      if (l) begin
        if ($urandom_range(0, 9) == 0)
          set_load(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        else
          set_load(bcd($urandom_range(0, 25)), bcd($urandom_range(0, 61)),
                   bcd($urandom_range(0, 3) == 0 ? $urandom_range(55, 61)
                                                 : $urandom_range(0, 59)),
                   1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) begin
          alarm_hh = mode24 ? load_hh : bcd((dec(load_hh) % 12) + (load_pm ? 12 : 0));
          alarm_mm = bcd((dec(load_mm) + 1) % 60);
        end
      end
      step(r, e, l);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
